// File: rtl/dme_pwr_seq_if.sv
// ---------------------------------------------------------------------------
// dme_pwr_seq_if
// Bundles the platform-side power/reset signals and the sequenced outputs of
// the DME power sequencer.
//   master : platform side, drives PSU/platform/DME sense pins, observes the
//            sequenced rail enable, DME reset, fault flag and debug state.
//   slave  : the sequencer itself.
// Signals:
//   PWRGD_PS_PWROK_3V3 PSU power-good (async)
//   RST_PLTRST_N       platform reset, active-low (async)
//   DME_Absent         high when no DME is fitted (async)
//   DME_PWRGD          DME rail power-good (async)
//   DMEStatus[5:0]     raw DME status pins (async)
//   DME_PWR_EN         DME rail enable
//   RST_DME_N          sequenced DME reset, active-low
//   DMEStatusDeb[5:0]  debounced status
//   DME_Fault          latched power fault
//   SeqState[2:0]      current sequencer state code
// ---------------------------------------------------------------------------
interface dme_pwr_seq_if;
   logic       PWRGD_PS_PWROK_3V3;
   logic       RST_PLTRST_N;
   logic       DME_Absent;
   logic       DME_PWRGD;
   logic [5:0] DMEStatus;
   logic       DME_PWR_EN;
   logic       RST_DME_N;
   logic [5:0] DMEStatusDeb;
   logic       DME_Fault;
   logic [2:0] SeqState;

   modport master (
      output PWRGD_PS_PWROK_3V3, RST_PLTRST_N, DME_Absent, DME_PWRGD, DMEStatus,
      input  DME_PWR_EN, RST_DME_N, DMEStatusDeb, DME_Fault, SeqState
   );

   modport slave (
      input  PWRGD_PS_PWROK_3V3, RST_PLTRST_N, DME_Absent, DME_PWRGD, DMEStatus,
      output DME_PWR_EN, RST_DME_N, DMEStatusDeb, DME_Fault, SeqState
   );
endinterface

// File: rtl/dme_pwr_seq.sv
// ---------------------------------------------------------------------------
// dme_pwr_seq
// DME power/reset sequencer. Enables the DME rail once the PSU is good and a
// DME is fitted, waits (with timeout) for the DME rail power-good, holds the
// DME in reset for a programmed delay after power-good and platform reset
// release, and debounces the DME status pins. Power faults stay latched until
// the PSU power-good drops.
// Ports:
//   i_CLK_33M    system clock, rising edge
//   i_RST_SYS_N  asynchronous active-low reset
//   if_seq       dme_pwr_seq_if.slave (sense inputs, sequenced outputs)
// ---------------------------------------------------------------------------
module dme_pwr_seq #(
   parameter int TICK_DIV         = 33000,
   parameter int PWRGD_TIMEOUT_MS = 100,
   parameter int RST_DELAY_MS     = 10,
   parameter int DEB_CYCLES       = 4
) (
   input  logic         i_CLK_33M,
   input  logic         i_RST_SYS_N,
   dme_pwr_seq_if.slave if_seq
);

   localparam int MS_MAX = (PWRGD_TIMEOUT_MS > RST_DELAY_MS) ? PWRGD_TIMEOUT_MS : RST_DELAY_MS;
   localparam int MS_W   = $clog2(MS_MAX + 1);
   localparam int PS_W   = $clog2(TICK_DIV);
   localparam int DEB_W  = $clog2(DEB_CYCLES + 1);

   // Synchronizer bit order: {DMEStatus, DME_PWRGD, DME_Absent, RST_PLTRST_N, PS_PWROK}.
   // Absent resets to 1 so a DME is never assumed present straight out of reset.
   localparam logic [9:0] SYNC_RST = 10'h004;

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_PWR_ON   = 3'd1,
      ST_WAIT_RST = 3'd2,
      ST_RUN      = 3'd3,
      ST_FAULT    = 3'd4
   } state_t;

   logic [9:0]       w_asyncIn;
   logic [9:0]       r_syncMeta;
   logic [9:0]       r_sync;
   logic             w_psGood;
   logic             w_pltRstN;
   logic             w_absent;
   logic             w_dmePwrGd;
   logic [5:0]       w_status;

   state_t           r_state;
   state_t           w_nextState;
   logic             w_enter;
   logic [PS_W-1:0]  r_presc;
   logic             w_tick;
   logic [MS_W-1:0]  r_ms;
   logic [MS_W-1:0]  w_msNext;

   logic             r_pwrEn;
   logic             r_rstDmeN;
   logic             r_fault;
   logic [2:0]       r_seqState;
   logic [5:0]       r_deb;
   logic [DEB_W-1:0] r_debCnt [6];

   assign w_asyncIn = {if_seq.DMEStatus, if_seq.DME_PWRGD, if_seq.DME_Absent,
                       if_seq.RST_PLTRST_N, if_seq.PWRGD_PS_PWROK_3V3};

   // Two-flop synchronizer for every asynchronous input.
   always_ff @(posedge i_CLK_33M or negedge i_RST_SYS_N) begin
      if (!i_RST_SYS_N) begin
         r_syncMeta <= SYNC_RST;
         r_sync     <= SYNC_RST;
      end else begin
         r_syncMeta <= w_asyncIn;
         r_sync     <= r_syncMeta;
      end
   end

   assign w_psGood   = r_sync[0];
   assign w_pltRstN  = r_sync[1];
   assign w_absent   = r_sync[2];
   assign w_dmePwrGd = r_sync[3];
   assign w_status   = r_sync[9:4];

   // The ms count as it will be after this edge; using the look-ahead value
   // lets a state leave on the very edge that counts its final tick.
   assign w_tick   = (r_presc == PS_W'(TICK_DIV - 1));
   assign w_msNext = (w_tick && (r_ms != MS_W'(MS_MAX))) ? r_ms + MS_W'(1) : r_ms;

   // Next-state logic. Loss of PSU power-good or DME removal dominate every
   // state except FAULT, which only the PSU dropping can clear.
   always_comb begin
      w_nextState = r_state;
      if (r_state == ST_FAULT) begin
         if (!w_psGood) w_nextState = ST_OFF;
      end else if (!w_psGood || w_absent) begin
         w_nextState = ST_OFF;
      end else begin
         case (r_state)
            ST_OFF:      w_nextState = ST_PWR_ON;
            ST_PWR_ON: begin
               if (w_dmePwrGd)                                  w_nextState = ST_WAIT_RST;
               else if (w_msNext >= MS_W'(PWRGD_TIMEOUT_MS))    w_nextState = ST_FAULT;
            end
            ST_WAIT_RST: begin
               if (!w_dmePwrGd)                                           w_nextState = ST_FAULT;
               else if ((w_msNext >= MS_W'(RST_DELAY_MS)) && w_pltRstN)   w_nextState = ST_RUN;
            end
            ST_RUN: begin
               if (!w_dmePwrGd)     w_nextState = ST_FAULT;
               else if (!w_pltRstN) w_nextState = ST_WAIT_RST;
            end
            default:     w_nextState = ST_OFF;
         endcase
      end
   end

   assign w_enter = (w_nextState != r_state);

   // State register, ms timebase and outputs. The timebase restarts on every
   // state change so each state times itself from its own entry edge; outputs
   // are decoded from the next state so they move together with SeqState.
   always_ff @(posedge i_CLK_33M or negedge i_RST_SYS_N) begin
      if (!i_RST_SYS_N) begin
         r_state    <= ST_OFF;
         r_presc    <= '0;
         r_ms       <= '0;
         r_pwrEn    <= 1'b0;
         r_rstDmeN  <= 1'b0;
         r_fault    <= 1'b0;
         r_seqState <= 3'd0;
      end else begin
         r_state    <= w_nextState;
         r_presc    <= (w_enter || w_tick) ? '0 : r_presc + PS_W'(1);
         r_ms       <= w_enter ? '0 : w_msNext;
         r_pwrEn    <= (w_nextState == ST_PWR_ON) || (w_nextState == ST_WAIT_RST) ||
                       (w_nextState == ST_RUN);
         r_rstDmeN  <= (w_nextState == ST_RUN);
         r_fault    <= (w_nextState == ST_FAULT);
         r_seqState <= w_nextState;
      end
   end

   // Per-bit debounce: a bit only flips after DEB_CYCLES consecutive synced
   // samples disagree with the current debounced value.
   always_ff @(posedge i_CLK_33M or negedge i_RST_SYS_N) begin
      if (!i_RST_SYS_N) begin
         r_deb <= '0;
         for (int b = 0; b < 6; b++) r_debCnt[b] <= '0;
      end else begin
         for (int b = 0; b < 6; b++) begin
            if (w_status[b] == r_deb[b]) begin
               r_debCnt[b] <= '0;
            end else if (r_debCnt[b] == DEB_W'(DEB_CYCLES - 1)) begin
               r_deb[b]    <= ~r_deb[b];
               r_debCnt[b] <= '0;
            end else begin
               r_debCnt[b] <= r_debCnt[b] + DEB_W'(1);
            end
         end
      end
   end

   assign if_seq.DME_PWR_EN   = r_pwrEn;
   assign if_seq.RST_DME_N    = r_rstDmeN;
   assign if_seq.DME_Fault    = r_fault;
   assign if_seq.SeqState     = r_seqState;
   assign if_seq.DMEStatusDeb = r_deb;

endmodule

// File: tb/tb_dme_pwr_seq.sv
// ---------------------------------------------------------------------------
// tb_dme_pwr_seq
// Directed and randomized bench for dme_pwr_seq with a cycle-level reference
// model that times each state by elapsed clock cycles and debounces by
// looking at a window of recent synchronized samples.
// ---------------------------------------------------------------------------
module tb_dme_pwr_seq;

   localparam int TD = 4;
   localparam int TO = 3;
   localparam int RD = 2;
   localparam int DB = 4;

   logic clk  = 1'b0;
   logic rstN = 1'b1;

   dme_pwr_seq_if ifc ();

   dme_pwr_seq #(
      .TICK_DIV         (TD),
      .PWRGD_TIMEOUT_MS (TO),
      .RST_DELAY_MS     (RD),
      .DEB_CYCLES       (DB)
   ) dut (
      .i_CLK_33M   (clk),
      .i_RST_SYS_N (rstN),
      .if_seq      (ifc.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Stimulus levels driven onto the interface before each clock edge.
   logic       ps   = 1'b0;
   logic       plt  = 1'b0;
   logic       abs  = 1'b1;
   logic       pg   = 1'b0;
   logic [5:0] stat = 6'h00;

   // Reference model state: spec state code, cycles since state entry,
   // two-stage input pipeline, debounced value and recent status samples.
   int         mSt;
   int         mElapsed;
   logic [9:0] mSync1;
   logic [9:0] mSync2;
   logic [5:0] mDeb;
   logic [5:0] mHist[$];

   int cnt;
   int fallEdge;
   int riseEdge;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      mSt      = 0;
      mElapsed = 0;
      mSync1   = 10'h004;
      mSync2   = 10'h004;
      mDeb     = 6'h00;
      mHist.delete();
   endtask

   task automatic modelEdge();
      logic       sPs, sPlt, sAbs, sPg;
      logic [5:0] sStat;
      logic [5:0] flip;
      logic       allDiff;
      int         nxt;
      if (!rstN) begin
         modelReset();
         return;
      end
      {sStat, sPg, sAbs, sPlt, sPs} = mSync2;
      nxt = mSt;
      if (mSt == 4) begin
         if (!sPs) nxt = 0;
      end else if (!sPs || sAbs) begin
         nxt = 0;
      end else begin
         case (mSt)
            0: nxt = 1;
            1: if (sPg) nxt = 2;
               else if (mElapsed + 1 >= TO * TD) nxt = 4;
            2: if (!sPg) nxt = 4;
               else if ((mElapsed + 1 >= RD * TD) && sPlt) nxt = 3;
            3: if (!sPg) nxt = 4;
               else if (!sPlt) nxt = 2;
            default: nxt = 0;
         endcase
      end
      mElapsed = (nxt != mSt) ? 0 : mElapsed + 1;
      mSt      = nxt;
      mHist.push_back(sStat);
      if (mHist.size() > DB) void'(mHist.pop_front());
      flip = 6'h00;
      if (mHist.size() == DB) begin
         for (int b = 0; b < 6; b++) begin
            allDiff = 1'b1;
            foreach (mHist[i]) if (mHist[i][b] == mDeb[b]) allDiff = 1'b0;
            flip[b] = allDiff;
         end
      end
      mDeb   = mDeb ^ flip;
      mSync2 = mSync1;
      mSync1 = {stat, pg, abs, plt, ps};
   endtask

   task automatic checkAll();
      checkOutput("DME_PWR_EN", ifc.DME_PWR_EN, (mSt >= 1 && mSt <= 3));
      checkOutput("RST_DME_N", ifc.RST_DME_N, (mSt == 3));
      checkOutput("DME_Fault", ifc.DME_Fault, (mSt == 4));
      checkOutput("SeqState", ifc.SeqState, 32'(mSt));
      checkOutput("DMEStatusDeb", ifc.DMEStatusDeb, mDeb);
   endtask

   task automatic driveInputs();
      ifc.PWRGD_PS_PWROK_3V3 = ps;
      ifc.RST_PLTRST_N       = plt;
      ifc.DME_Absent         = abs;
      ifc.DME_PWRGD          = pg;
      ifc.DMEStatus          = stat;
   endtask

   task automatic applyStimulus(input int n);
      repeat (n) begin
         driveInputs();
         @(posedge clk);
         modelEdge();
         #1;
         checkAll();
      end
   endtask

   task automatic stepUntilState(input int target, input int budget);
      int n = 0;
      while (mSt != target && n < budget) begin
         applyStimulus(1);
         n++;
      end
      checkOutput("reach_state", ifc.SeqState, 32'(target));
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      modelReset();
      driveInputs();
      #1 rstN = 1'b0;
      #2;
      checkOutput("rst_pwr_en", ifc.DME_PWR_EN, 0);
      checkOutput("rst_rst_dme_n", ifc.RST_DME_N, 0);
      checkOutput("rst_fault", ifc.DME_Fault, 0);
      checkOutput("rst_state", ifc.SeqState, 0);
      checkOutput("rst_deb", ifc.DMEStatusDeb, 0);
      applyStimulus(2);
      rstN = 1'b1;

      // DME absent with PSU good: must never leave OFF
      ps = 1'b1; abs = 1'b1; pg = 1'b0; plt = 1'b1;
      applyStimulus(10);
      checkOutput("absent_pwr_en", ifc.DME_PWR_EN, 0);

      // Normal bring-up, PSU good rises with DME present
      ps = 1'b0; abs = 1'b0;
      applyStimulus(4);
      ps = 1'b1;
      applyStimulus(1);
      cnt = 0;
      do begin applyStimulus(1); cnt++; end while (ifc.DME_PWR_EN !== 1'b1 && cnt < 10);
      checkOutput("pwr_en_latency", cnt, 2);
      applyStimulus(4);
      pg = 1'b1;
      stepUntilState(2, 12);
      cnt = 0;
      do begin applyStimulus(1); cnt++; end while (ifc.RST_DME_N !== 1'b1 && cnt < 20);
      checkOutput("rst_delay", cnt, 8);
      checkOutput("run_state", ifc.SeqState, 3);

      // Debounce: short glitch rejected, held value accepted after 6 cycles
      stat = 6'h08;
      applyStimulus(3);
      stat = 6'h00;
      applyStimulus(8);
      checkOutput("deb_glitch", ifc.DMEStatusDeb, 0);
      stat = 6'h2A;
      cnt = 0;
      do begin applyStimulus(1); cnt++; end while (ifc.DMEStatusDeb !== 6'h2A && cnt < 15);
      checkOutput("deb_latency", cnt, 6);
      for (int i = 0; i < 12; i++) begin
         stat = 6'($urandom);
         applyStimulus($urandom_range(1, 8));
      end

      // Platform reset pulse in RUN restarts the reset delay
      fallEdge = -1; riseEdge = -1;
      for (int i = 1; i <= 30; i++) begin
         plt = (i <= 3) ? 1'b0 : 1'b1;
         applyStimulus(1);
         if (fallEdge < 0 && ifc.RST_DME_N === 1'b0) fallEdge = i;
         else if (fallEdge >= 0 && riseEdge < 0 && ifc.RST_DME_N === 1'b1) riseEdge = i;
      end
      checkOutput("pltrst_fell", (fallEdge >= 0), 1);
      checkOutput("pltrst_rose", (riseEdge >= 0), 1);
      checkOutput("pltrst_gap_ge8", ((riseEdge - fallEdge) >= 8), 1);

      // Rail loss in RUN latches a fault that ignores absent and power-good
      pg = 1'b0;
      applyStimulus(4);
      checkOutput("railloss_state", ifc.SeqState, 4);
      checkOutput("railloss_pwr_en", ifc.DME_PWR_EN, 0);
      for (int i = 0; i < 6; i++) begin
         abs = 1'($urandom_range(0, 1));
         pg  = 1'($urandom_range(0, 1));
         applyStimulus(2);
      end
      checkOutput("fault_held", ifc.DME_Fault, 1);
      abs = 1'b0; pg = 1'b0; ps = 1'b0;
      applyStimulus(3);
      checkOutput("fault_clear_state", ifc.SeqState, 0);
      checkOutput("fault_clear_flag", ifc.DME_Fault, 0);

      // Power-good timeout after 12 cycles in PWR_ON
      ps = 1'b1;
      stepUntilState(1, 10);
      cnt = 0;
      do begin applyStimulus(1); cnt++; end while (ifc.DME_Fault !== 1'b1 && cnt < 20);
      checkOutput("timeout_latency", cnt, 12);
      checkOutput("timeout_pwr_en", ifc.DME_PWR_EN, 0);
      checkOutput("timeout_state", ifc.SeqState, 4);
      ps = 1'b0;
      applyStimulus(4);

      // Power-good seen on the same edge as the final timeout tick wins
      ps = 1'b1;
      stepUntilState(1, 10);
      applyStimulus(9);
      pg = 1'b1;
      applyStimulus(3);
      checkOutput("pg_beats_timeout", ifc.SeqState, 2);
      stepUntilState(3, 20);

      // DME pulled while running: OFF two cycles after the first sampling edge
      abs = 1'b1;
      applyStimulus(2);
      checkOutput("absent_not_early", ifc.RST_DME_N, 1);
      applyStimulus(1);
      checkOutput("absent_run_pwr_en", ifc.DME_PWR_EN, 0);
      checkOutput("absent_run_rst", ifc.RST_DME_N, 0);
      checkOutput("absent_run_state", ifc.SeqState, 0);

      // Asynchronous reset in the middle of WAIT_RST
      abs = 1'b0; plt = 1'b0; pg = 1'b1; ps = 1'b1;
      stepUntilState(2, 20);
      applyStimulus(3);
      #2 rstN = 1'b0;
      #1;
      modelReset();
      checkOutput("async_rst_pwr_en", ifc.DME_PWR_EN, 0);
      checkOutput("async_rst_state", ifc.SeqState, 0);
      checkAll();
      applyStimulus(2);
      rstN = 1'b1;
      plt  = 1'b1;
      applyStimulus(1);
      checkOutput("restart_from_off", ifc.SeqState, 0);
      stepUntilState(3, 30);

      // Randomized segments against the reference model
      for (int i = 0; i < 80; i++) begin
         ps   = ($urandom_range(0, 9) != 0);
         abs  = ($urandom_range(0, 7) == 0);
         pg   = ($urandom_range(0, 3) != 0);
         plt  = ($urandom_range(0, 4) != 0);
         stat = 6'($urandom);
         applyStimulus($urandom_range(1, 15));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dme_pwr_seq.md
# dme_pwr_seq

DME power/reset sequencer that sits directly upstream of the DME interface-init stage. It enables DME power only when the PSU is good and a DME is present, and waits (with timeout) for the DME's own power-good. It holds the DME in reset for a programmed delay after power-good and platform reset release, then hands the init stage a clean, sequenced `RST_DME_N` and debounced `DMEStatus`. Power faults are latched until the PSU power cycles.

## Interface
- `TICK_DIV`, 33000: clock cycles per 1 ms tick (≥2).
- `PWRGD_TIMEOUT_MS`, 100: ms allowed for `DME_PWRGD` after `DME_PWR_EN` (≥1).
- `RST_DELAY_MS`, 10: ms `RST_DME_N` stays low after entering WAIT_RST (≥1).
- `DEB_CYCLES`, 4: consecutive equal samples needed to accept a `DMEStatus` bit change (≥1).
- `CLK_33M` in 1: system clock; all flops on rising edge.
- `RST_SYS_N` in 1: reset, asynchronous assert, active-low.
- `PWRGD_PS_PWROK_3V3` in 1: PSU power-good, asynchronous.
- `RST_PLTRST_N` in 1: platform reset, active-low, asynchronous.
- `DME_Absent` in 1: high = no DME fitted, asynchronous.
- `DME_PWRGD` in 1: DME rail power-good, asynchronous.
- `DMEStatus` in 6: raw DME status pins, asynchronous.
- `DME_PWR_EN` out 1: DME rail enable.
- `RST_DME_N` out 1: sequenced DME reset, active-low.
- `DMEStatusDeb` out 6: debounced status.
- `DME_Fault` out 1: latched power fault.
- `SeqState` out 3: current state encoding, for debug/CPLD register.

## Operation
- Every asynchronous input passes through a 2-flop synchronizer. Reset values: `DME_Absent` sync = 1, all others = 0.
- 1 ms tick: a prescaler counts 0..TICK_DIV-1 and pulses `tick` on wrap. The prescaler and ms counter clear on every state entry. The ms counter saturates and is sized to the larger of the two ms parameters.
- States and encoding: OFF=0, PWR_ON=1, WAIT_RST=2, RUN=3, FAULT=4. Codes 5–7 go to OFF.
- Transition priority, highest first, applied in every state except FAULT:
  1. PS power-good low → OFF.
  2. Absent high → OFF.
  3. State-specific rules below.
- OFF: if PS power-good is high and the DME is present → PWR_ON.
- PWR_ON:
  - `DME_PWRGD` high → WAIT_RST.
  - Otherwise, ms count reaching PWRGD_TIMEOUT_MS → FAULT.
- WAIT_RST:
  - `DME_PWRGD` low → FAULT.
  - ms count ≥ RST_DELAY_MS and `RST_PLTRST_N` high → RUN. If the delay has expired but `RST_PLTRST_N` is low, stay in WAIT_RST.
- RUN:
  - `DME_PWRGD` low → FAULT.
  - `RST_PLTRST_N` low → WAIT_RST. This restarts the delay.
- FAULT: exit only on PS power-good low → OFF. `DME_Absent` and `DME_PWRGD` are ignored.
- Registered outputs, decoded from next state:
  - `DME_PWR_EN` = 1 in PWR_ON, WAIT_RST and RUN.
  - `RST_DME_N` = 1 in RUN only.
  - `DME_Fault` = 1 in FAULT only.
  - `SeqState` = state code.
- Debounce, per bit: each bit keeps its own counter, which resets whenever the synced bit equals `DMEStatusDeb`. The output bit flips when DEB_CYCLES consecutive differing samples have been seen. Glitches shorter than DEB_CYCLES are rejected.
- Reset values: `DME_PWR_EN`=0, `RST_DME_N`=0, `DME_Fault`=0, `SeqState`=0, `DMEStatusDeb`=6'h00, all counters 0.

## Timing
- Input latency: an input stable before edge N is seen by the FSM after edge N+1. State and outputs update at edge N+2, giving 2-cycle latency with no combinational path from input to output.
- PWRGD timeout: FAULT is entered at the edge where the PWRGD_TIMEOUT_MS-th tick is counted, PWRGD_TIMEOUT_MS×TICK_DIV cycles after entering PWR_ON.
- Reset delay: `RST_DME_N` rises no earlier than RST_DELAY_MS×TICK_DIV cycles after entering WAIT_RST, plus the sync latency of `RST_PLTRST_N` if it is released later.
- Simultaneous `DME_PWRGD` rise and timeout tick in PWR_ON: go to WAIT_RST. Power-good wins.
- Simultaneous PS drop and fault condition: go to OFF.
- Reset asserted mid-sequence: all outputs go to their reset values immediately and asynchronously. The sequence restarts from OFF after release.
- Debounce latency: 2 sync cycles + DEB_CYCLES cycles from pin change to `DMEStatusDeb` change.

## Test plan
Parameters for all tests: TICK_DIV=4, PWRGD_TIMEOUT_MS=3, RST_DELAY_MS=2, DEB_CYCLES=4.

- Normal bring-up:
  - Stimulus: PS power-good=1, absent=0, `DME_PWRGD` rises 5 cycles after `DME_PWR_EN`, `RST_PLTRST_N`=1.
  - Response: `DME_PWR_EN`=1 at 2 cycles after PS power-good; `RST_DME_N` rises 8 cycles after WAIT_RST entry; `SeqState`=3.
- Timeout:
  - Stimulus: `DME_PWRGD` held 0.
  - Response: at 12 cycles after PWR_ON entry, `DME_Fault`=1, `DME_PWR_EN`=0, `SeqState`=4. The fault holds while absent toggles. It clears only after PS power-good drops, returning to `SeqState`=0.
- Platform reset and rail loss in RUN:
  - Stimulus: pulse `RST_PLTRST_N` low for 3 cycles.
  - Response: `RST_DME_N` goes 0 and then returns 1 no earlier than 8 cycles later.
  - Stimulus: then drop `DME_PWRGD`.
  - Response: `SeqState`=4.
- DME absent:
  - Stimulus: absent=1 with PS power-good=1.
  - Response: the block stays in OFF and `DME_PWR_EN` is never asserted.
  - Stimulus: pull absent high while in RUN.
  - Response: OFF, with both outputs 0 at 2 cycles.
- Debounce:
  - Stimulus: `DMEStatus`[3] 3-cycle glitch.
  - Response: `DMEStatusDeb` unchanged.
  - Stimulus: `DMEStatus`=6'h2A held.
  - Response: `DMEStatusDeb`=6'h2A exactly 6 cycles after the change.
- Async reset mid-WAIT_RST:
  - Stimulus: assert `RST_SYS_N` low between clock edges.
  - Response: all outputs are 0 immediately. After release, re-sequencing starts from OFF.
